// File: rtl/counter_pkg.sv
// Shared definitions for the up and down counter family: state encodings
// and the default counter width.
package counter_pkg;

  // Default counter width shared by the counter blocks.
  localparam int COUNTER_WIDTH = 4;

  // Two-bit state encoding for the timer control.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage : counter_pkg

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer. A start value is accepted through a
// valid/ready handshake and counted down to zero while en is high. Reaching
// zero raises a one-cycle terminal-count pulse. In auto-reload mode the
// counter restarts from the loaded period instead of stopping, giving a
// periodic tick.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             en,
  input  logic             abort,
  output logic             load_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic             mode_reg;
  logic             load_accept;

  // A new value can be taken whenever no count is in progress.
  assign load_ready  = (state == ST_IDLE) || (state == ST_DONE);
  assign load_accept = load_valid && load_ready;

  // Control state, count/reload datapath and registered status flags.
  // busy/done are written alongside every state change so they always
  // reflect the state the counter is in on the following cycle.
  // NOTE: every register here uses <= so all updates read pre-edge values;
  // a blocking '=' would let count see its own new value within the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      mode_reg   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tc         <= 1'b0;
    end else if (abort) begin
      // Cancel overrides any pending load or count; the period is kept.
      state <= ST_IDLE;
      count <= ZERO;
      busy  <= 1'b0;
      done  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      // tc is a pulse: cleared unless a terminal count happens this edge.
      tc <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (load_accept) begin
            if (load_value == ZERO) begin
              // A zero period finishes immediately; auto_reload is ignored.
              state <= ST_DONE;
              count <= ZERO;
              busy  <= 1'b0;
              done  <= 1'b1;
              tc    <= 1'b1;
            end else begin
              state      <= ST_RUN;
              count      <= load_value;
              reload_reg <= load_value;
              mode_reg   <= auto_reload;
              busy       <= 1'b1;
              done       <= 1'b0;
            end
          end
        end

        ST_RUN: begin
          if (en) begin
            if (count == ONE) begin
              tc <= 1'b1;
              if (mode_reg) begin
                // Periodic mode: restart so the period is reload_reg cycles.
                count <= reload_reg;
              end else begin
                state <= ST_DONE;
                count <= ZERO;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              // count is at least 2 here, so this never wraps.
              count <= count - ONE;
            end
          end
        end

        default: begin
          // Unused encoding: recover to a clean idle state.
          state <= ST_IDLE;
          count <= ZERO;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer (WIDTH=4). A behavioural
// reference model predicts the outputs of each cycle as the stimulus is
// driven; the prediction is queued and compared after the clock edge.
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         auto_reload;
  logic         en;
  logic         abort;
  logic         load_ready;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         tc;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .en         (en),
    .abort      (abort),
    .load_ready (load_ready),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         tc;
    logic         ready;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 = idle, 1 = running, 2 = finished.
  int           m_state = 0;
  logic [W-1:0] m_cnt   = '0;
  logic [W-1:0] m_rel   = '0;
  logic         m_mode  = 1'b0;
  logic         m_tc    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic r, input logic lv, input logic [W-1:0] lval,
                            input logic ar, input logic e, input logic ab);
    if (r) begin
      m_state = 0; m_cnt = '0; m_rel = '0; m_mode = 1'b0; m_tc = 1'b0;
    end else if (ab) begin
      m_state = 0; m_cnt = '0; m_tc = 1'b0;
    end else begin
      m_tc = 1'b0;
      if (m_state != 1 && lv) begin
        if (lval == '0) begin
          m_state = 2; m_cnt = '0; m_tc = 1'b1;
        end else begin
          m_state = 1; m_cnt = lval; m_rel = lval; m_mode = ar;
        end
      end else if (m_state == 1 && e) begin
        if (m_cnt == 1) begin
          m_tc = 1'b1;
          if (m_mode) m_cnt = m_rel;
          else begin
            m_state = 2; m_cnt = '0;
          end
        end else begin
          m_cnt = m_cnt - 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, queue the prediction, compare after the edge.
  task automatic cycle(input logic r, input logic lv, input logic [W-1:0] lval,
                       input logic ar, input logic e, input logic ab);
    exp_t x;
    exp_t got;
    @(negedge clk);
    rst = r; load_valid = lv; load_value = lval; auto_reload = ar; en = e; abort = ab;
    #1;
    check("load_ready_pre", {31'd0, load_ready}, {31'd0, (m_state != 1)});
    model_step(r, lv, lval, ar, e, ab);
    x.count = m_cnt;
    x.busy  = (m_state == 1);
    x.done  = (m_state == 2);
    x.tc    = m_tc;
    x.ready = (m_state != 1);
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = '{count: count, busy: busy, done: done, tc: tc, ready: load_ready};
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("count", {28'd0, got.count}, {28'd0, x.count});
      check("busy",  {31'd0, got.busy},  {31'd0, x.busy});
      check("done",  {31'd0, got.done},  {31'd0, x.done});
      check("tc",    {31'd0, got.tc},    {31'd0, x.tc});
      check("ready", {31'd0, got.ready}, {31'd0, x.ready});
    end
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, e, 1'b0);
  endtask

  task automatic load(input logic [W-1:0] v, input logic ar, input logic e);
    cycle(1'b0, 1'b1, v, ar, e, 1'b0);
  endtask

  initial begin
    logic [5:0] en_pat;
    int tc_seen;
    rst = 1'b1; load_valid = 1'b0; load_value = '0; auto_reload = 1'b0;
    en = 1'b0; abort = 1'b0;

    // Reset state.
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    check("reset_count", {28'd0, count}, 32'd0);
    check("reset_ready", {31'd0, load_ready}, 32'd1);

    // 1: one-shot count of 5; tc must fall on the 5th cycle after the load.
    load(4'd5, 1'b0, 1'b1);
    tc_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (tc) tc_seen = i;
    end
    check("t1_tc_cycle", tc_seen, 5);
    check("t1_done", {31'd0, done}, 32'd1);
    idle(2, 1'b1);

    // 2: auto-reload period 3 for ten enabled cycles.
    load(4'd3, 1'b1, 1'b1);
    idle(10, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

    // 3: load 4 with a gapped enable pattern.
    load(4'd4, 1'b0, 1'b1);
    en_pat = 6'b111001;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b0, en_pat[i], 1'b0);
    check("t3_done", {31'd0, done}, 32'd1);
    idle(1, 1'b1);

    // 4: zero load from DONE finishes at once, busy never set.
    load(4'd0, 1'b1, 1'b1);
    check("t4_tc", {31'd0, tc}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    idle(2, 1'b1);

    // 5: abort at count 2 while a load is offered.
    load(4'd6, 1'b0, 1'b1);
    idle(4, 1'b1);
    check("t5_pre_abort", {28'd0, count}, 32'd2);
    cycle(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);

    // 6: reset mid-run at count 7.
    load(4'd15, 1'b0, 1'b1);
    idle(8, 1'b1);
    check("t6_pre_rst", {28'd0, count}, 32'd7);
    cycle(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);

    // Maximum load counts fully; then period-1 auto-reload ticks every enabled cycle.
    load(4'd15, 1'b0, 1'b1);
    idle(16, 1'b1);
    load(4'd1, 1'b1, 1'b1);
    idle(3, 1'b1);
    idle(1, 1'b0);
    idle(2, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Random traffic, mostly loads and enables with occasional abort/reset.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
            W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 3));
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_down_counter_timer
